// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slave bus between the instruction and data
// ports: grants per transaction, decodes the address map, returns the response.
module mem_arbiter #(
  parameter logic [31:0] bram_base_addr  = 32'h0000_0000,
  parameter logic [31:0] bram_top_addr   = 32'h0000_0400,
  parameter logic [31:0] uart_base_addr  = 32'h0010_0000,
  parameter logic [31:0] uart_top_addr   = 32'h0010_0004,
  parameter logic [31:0] clint_base_addr = 32'h0200_0000,
  parameter logic [31:0] clint_top_addr  = 32'h0200_C000,
  parameter logic [31:0] avl_base_addr   = 32'h8000_0000,
  parameter logic [31:0] avl_top_addr    = 32'h9000_0000,
  parameter int unsigned timeout_cycles  = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic        imem_instr,
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  input  logic [3:0]  imem_wstrb,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  output logic        imem_error,
  input  logic        dmem_valid,
  input  logic        dmem_instr,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        dmem_error,
  output logic        bram_valid,
  output logic        uart_valid,
  output logic        clint_valid,
  output logic        avl_valid,
  output logic        slv_instr,
  output logic [31:0] slv_addr,
  output logic [31:0] slv_wdata,
  output logic [3:0]  slv_wstrb,
  input  logic        bram_ready,
  input  logic        uart_ready,
  input  logic        clint_ready,
  input  logic        avl_ready,
  input  logic [31:0] bram_rdata,
  input  logic [31:0] uart_rdata,
  input  logic [31:0] clint_rdata,
  input  logic [31:0] avl_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ERR = 2'd2} state_t;

  // One-hot select: bit0 bram, bit1 uart, bit2 clint, bit3 avl; zero = unmapped.
  function automatic logic [3:0] decode(input logic [31:0] a);
    logic [3:0] hit;
    hit[0] = (a >= bram_base_addr)  && (a < bram_top_addr);
    hit[1] = (a >= uart_base_addr)  && (a < uart_top_addr);
    hit[2] = (a >= clint_base_addr) && (a < clint_top_addr);
    hit[3] = (a >= avl_base_addr)   && (a < avl_top_addr);
    return hit;
  endfunction

  state_t      state_q, state_d;
  logic        last_q, last_d;     // 0 = imem, 1 = dmem
  logic        owner_q, owner_d;
  logic [3:0]  sel_q, sel_d;
  logic        instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] cnt_q, cnt_d;

  logic        gnt_dmem_s;
  logic        req_any_s;
  logic        req_instr_s;
  logic [31:0] req_addr_s;
  logic [31:0] req_wdata_s;
  logic [3:0]  req_wstrb_s;
  logic [3:0]  dec_s;
  logic        slv_ready_s;
  logic [31:0] slv_rdata_s;
  logic        timeout_s;
  logic        done_s;
  logic        err_s;

  // Request selection: a tie goes to whoever was not granted last.
  always_comb begin
    req_any_s   = imem_valid | dmem_valid;
    gnt_dmem_s  = dmem_valid & (~imem_valid | ~last_q);
    req_instr_s = gnt_dmem_s ? dmem_instr : imem_instr;
    req_addr_s  = gnt_dmem_s ? dmem_addr  : imem_addr;
    req_wdata_s = gnt_dmem_s ? dmem_wdata : imem_wdata;
    req_wstrb_s = gnt_dmem_s ? dmem_wstrb : imem_wstrb;
    dec_s       = decode(req_addr_s);
    slv_ready_s = |(sel_q & {avl_ready, clint_ready, uart_ready, bram_ready});
    timeout_s   = (timeout_cycles != 32'd0) && (cnt_q == (timeout_cycles - 32'd1));
  end

  // Read-data return mux driven by the registered slave select.
  always_comb begin
    slv_rdata_s = 32'h0;
    case (sel_q)
      4'b0001: slv_rdata_s = bram_rdata;
      4'b0010: slv_rdata_s = uart_rdata;
      4'b0100: slv_rdata_s = clint_rdata;
      4'b1000: slv_rdata_s = avl_rdata;
      default: slv_rdata_s = 32'h0;
    endcase
  end

  // Next-state logic for the transaction FSM and its payload registers.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any_s) begin
          owner_d = gnt_dmem_s;
          instr_d = req_instr_s;
          addr_d  = req_addr_s;
          wdata_d = req_wdata_s;
          wstrb_d = req_wstrb_s;
          sel_d   = dec_s;
          cnt_d   = 32'd0;
          state_d = (dec_s != 4'b0000) ? BUSY : ERR;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (slv_ready_s) begin
          done_s  = 1'b1;
          sel_d   = 4'b0000;
          last_d  = owner_q;
          state_d = IDLE;
        end else if (timeout_s) begin
          done_s  = 1'b1;
          err_s   = 1'b1;
          sel_d   = 4'b0000;
          last_d  = owner_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ERR: begin
        done_s  = 1'b1;
        err_s   = 1'b1;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        sel_d   = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  // State and payload registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      owner_q <= 1'b0;
      sel_q   <= 4'b0000;
      instr_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Completion is returned only to the owner; error responses carry no data.
  always_comb begin
    imem_ready = 1'b0;
    imem_error = 1'b0;
    imem_rdata = 32'h0;
    dmem_ready = 1'b0;
    dmem_error = 1'b0;
    dmem_rdata = 32'h0;
    if (done_s) begin
      if (owner_q) begin
        dmem_ready = 1'b1;
        dmem_error = err_s;
        dmem_rdata = err_s ? 32'h0 : slv_rdata_s;
      end else begin
        imem_ready = 1'b1;
        imem_error = err_s;
        imem_rdata = err_s ? 32'h0 : slv_rdata_s;
      end
    end else begin
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
    end
  end

  assign bram_valid  = sel_q[0];
  assign uart_valid  = sel_q[1];
  assign clint_valid = sel_q[2];
  assign avl_valid   = sel_q[3];
  assign slv_instr   = instr_q;
  assign slv_addr    = addr_q;
  assign slv_wdata   = wdata_q;
  assign slv_wstrb   = wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each task drives one scenario and checks
// hand-computed values sampled 1-2 time units after the rising edge.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_valid, imem_instr, dmem_valid, dmem_instr;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
  logic [3:0]  imem_wstrb, dmem_wstrb;
  logic        imem_ready, imem_error, dmem_ready, dmem_error;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        bram_valid, uart_valid, clint_valid, avl_valid;
  logic        slv_instr;
  logic [31:0] slv_addr, slv_wdata;
  logic [3:0]  slv_wstrb;
  logic        bram_ready, uart_ready, clint_ready, avl_ready;
  logic [31:0] bram_rdata, uart_rdata, clint_rdata, avl_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.timeout_cycles(8)) dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_error(imem_error),
    .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .dmem_error(dmem_error),
    .bram_valid(bram_valid), .uart_valid(uart_valid), .clint_valid(clint_valid),
    .avl_valid(avl_valid), .slv_instr(slv_instr), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
    .bram_ready(bram_ready), .uart_ready(uart_ready), .clint_ready(clint_ready),
    .avl_ready(avl_ready), .bram_rdata(bram_rdata), .uart_rdata(uart_rdata),
    .clint_rdata(clint_rdata), .avl_rdata(avl_rdata)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    imem_valid = 1'b0; imem_instr = 1'b0; imem_addr = 32'h0; imem_wdata = 32'h0; imem_wstrb = 4'h0;
    dmem_valid = 1'b0; dmem_instr = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
    bram_ready = 1'b0; uart_ready = 1'b0; clint_ready = 1'b0; avl_ready = 1'b0;
    bram_rdata = 32'hDEAD_BEEF; uart_rdata = 32'h0000_0055;
    clint_rdata = 32'h00C0_FFEE; avl_rdata = 32'hA5A5_5A5A;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bram_valid, uart_valid, clint_valid, avl_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb} !== 73'h0) begin
      $display("FAIL reset_slave: got %h want 0", {bram_valid, uart_valid, clint_valid, avl_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb});
      n_bad++;
    end
    n_cmp++;
    if ({imem_ready, imem_error, imem_rdata, dmem_ready, dmem_error, dmem_rdata} !== 68'h0) begin
      $display("FAIL reset_req: got %h want 0", {imem_ready, imem_error, imem_rdata, dmem_ready, dmem_error, dmem_rdata});
      n_bad++;
    end
  endtask

  // Both requesters continuously valid: grants must go d,i,d,i,...
  task automatic test_round_robin();
    logic want_d;
    imem_valid = 1'b1; imem_instr = 1'b1; imem_addr = 32'h0000_0020;
    dmem_valid = 1'b1; dmem_addr = 32'h0000_0030;
    bram_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      want_d = ((k % 2) == 0);
      tick();
      n_cmp++;
      if ({dmem_ready, imem_ready} !== {want_d, ~want_d}) begin
        $display("FAIL rr_grant[%0d]: got d/i=%b%b want %b%b", k, dmem_ready, imem_ready, want_d, ~want_d);
        n_bad++;
      end
      n_cmp++;
      if (slv_addr !== (want_d ? 32'h0000_0030 : 32'h0000_0020)) begin
        $display("FAIL rr_addr[%0d]: got %h want %h", k, slv_addr, want_d ? 32'h0000_0030 : 32'h0000_0020);
        n_bad++;
      end
      n_cmp++;
      if ((want_d ? imem_rdata : dmem_rdata) !== 32'h0) begin
        $display("FAIL rr_other_rdata[%0d]: got %h want 0", k, want_d ? imem_rdata : dmem_rdata);
        n_bad++;
      end
      if (k == 7) begin
        imem_valid = 1'b0; dmem_valid = 1'b0;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_dmem_read();
    dmem_valid = 1'b1; dmem_addr = 32'h0000_0010;
    bram_ready = 1'b1;
    #1;
    n_cmp++;
    if ({bram_valid, dmem_ready} !== 2'b00) begin
      $display("FAIL rd_idle: got valid/ready=%b%b want 00", bram_valid, dmem_ready);
      n_bad++;
    end
    tick();
    n_cmp++;
    if ({bram_valid, uart_valid, clint_valid, avl_valid} !== 4'b1000) begin
      $display("FAIL rd_sel: got %b want 1000", {bram_valid, uart_valid, clint_valid, avl_valid});
      n_bad++;
    end
    n_cmp++;
    if ({dmem_ready, dmem_error, dmem_rdata, imem_ready} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
      $display("FAIL rd_resp: got r=%b e=%b d=%h ir=%b want 1 0 deadbeef 0", dmem_ready, dmem_error, dmem_rdata, imem_ready);
      n_bad++;
    end
    dmem_valid = 1'b0;
    tick();
    n_cmp++;
    if ({bram_valid, dmem_ready} !== 2'b00) begin
      $display("FAIL rd_after: got valid/ready=%b%b want 00", bram_valid, dmem_ready);
      n_bad++;
    end
    idle_inputs();
  endtask

  task automatic test_uart_write();
    dmem_valid = 1'b1; dmem_addr = 32'h0010_0000; dmem_wdata = 32'h0000_0041; dmem_wstrb = 4'hF;
    tick();
    n_cmp++;
    if ({uart_valid, bram_valid, slv_addr, slv_wdata, slv_wstrb} !== {2'b10, 32'h0010_0000, 32'h0000_0041, 4'hF}) begin
      $display("FAIL wr_payload: got uv=%b bv=%b a=%h d=%h s=%h", uart_valid, bram_valid, slv_addr, slv_wdata, slv_wstrb);
      n_bad++;
    end
    bram_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      if (w > 0) tick();
      n_cmp++;
      if ({dmem_ready, uart_valid} !== 2'b01) begin
        $display("FAIL wr_wait[%0d]: got ready/valid=%b%b want 01", w, dmem_ready, uart_valid);
        n_bad++;
      end
    end
    tick();
    bram_ready = 1'b0; uart_ready = 1'b1;
    #1;
    n_cmp++;
    if ({dmem_ready, dmem_error, dmem_rdata} !== {2'b10, 32'h0000_0055}) begin
      $display("FAIL wr_done: got r=%b e=%b d=%h want 1 0 00000055", dmem_ready, dmem_error, dmem_rdata);
      n_bad++;
    end
    dmem_valid = 1'b0;
    tick();
    uart_ready = 1'b0;
    n_cmp++;
    if ({uart_valid, dmem_ready} !== 2'b00) begin
      $display("FAIL wr_after: got valid/ready=%b%b want 00", uart_valid, dmem_ready);
      n_bad++;
    end
    idle_inputs();
  endtask

  task automatic test_unmapped();
    imem_valid = 1'b1; imem_instr = 1'b1; imem_addr = 32'h0000_0400;
    bram_ready = 1'b1;
    tick();
    n_cmp++;
    if ({bram_valid, uart_valid, clint_valid, avl_valid} !== 4'b0000) begin
      $display("FAIL err_sel: got %b want 0000", {bram_valid, uart_valid, clint_valid, avl_valid});
      n_bad++;
    end
    n_cmp++;
    if ({imem_ready, imem_error, imem_rdata, dmem_ready} !== {2'b11, 32'h0, 1'b0}) begin
      $display("FAIL err_resp: got r=%b e=%b d=%h dr=%b want 1 1 0 0", imem_ready, imem_error, imem_rdata, dmem_ready);
      n_bad++;
    end
    imem_valid = 1'b0;
    tick();
    n_cmp++;
    if ({imem_ready, imem_error} !== 2'b00) begin
      $display("FAIL err_once: got r/e=%b%b want 00", imem_ready, imem_error);
      n_bad++;
    end
    imem_valid = 1'b1; imem_addr = 32'h0000_03FC;
    tick();
    n_cmp++;
    if ({bram_valid, imem_ready, imem_error, imem_rdata} !== {3'b110, 32'hDEAD_BEEF}) begin
      $display("FAIL edge_3fc: got bv=%b r=%b e=%b d=%h want 1 1 0 deadbeef", bram_valid, imem_ready, imem_error, imem_rdata);
      n_bad++;
    end
    imem_valid = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    dmem_valid = 1'b1; dmem_addr = 32'h8000_0000;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_cmp++;
      if ({avl_valid, dmem_ready, dmem_error} !== {1'b1, (c == 8), (c == 8)}) begin
        $display("FAIL to_cycle[%0d]: got v=%b r=%b e=%b", c, avl_valid, dmem_ready, dmem_error);
        n_bad++;
      end
    end
    n_cmp++;
    if (dmem_rdata !== 32'h0) begin
      $display("FAIL to_rdata: got %h want 0", dmem_rdata);
      n_bad++;
    end
    dmem_valid = 1'b0;
    tick();
    n_cmp++;
    if ({avl_valid, dmem_ready} !== 2'b00) begin
      $display("FAIL to_after: got valid/ready=%b%b want 00", avl_valid, dmem_ready);
      n_bad++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    dmem_valid = 1'b1; dmem_addr = 32'h0200_BFF8; dmem_wdata = 32'h1111_2222; dmem_wstrb = 4'h3;
    tick();
    n_cmp++;
    if (clint_valid !== 1'b1) begin
      $display("FAIL rst_mid_sel: got %b want 1", clint_valid);
      n_bad++;
    end
    tick();
    reset = 1'b1; dmem_valid = 1'b0;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({bram_valid, uart_valid, clint_valid, avl_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb,
         imem_ready, imem_error, imem_rdata, dmem_ready, dmem_error, dmem_rdata} !== 141'h0) begin
      $display("FAIL rst_mid_outs: clint_valid=%b slv_addr=%h dmem_ready=%b", clint_valid, slv_addr, dmem_ready);
      n_bad++;
    end
    dmem_valid = 1'b1; dmem_addr = 32'h0200_0000; dmem_wstrb = 4'h0;
    clint_ready = 1'b1;
    tick();
    n_cmp++;
    if ({clint_valid, dmem_ready, dmem_error, dmem_rdata} !== {3'b110, 32'h00C0_FFEE}) begin
      $display("FAIL rst_mid_new: got v=%b r=%b e=%b d=%h want 1 1 0 00c0ffee", clint_valid, dmem_ready, dmem_error, dmem_rdata);
      n_bad++;
    end
    dmem_valid = 1'b0;
    tick();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_dmem_read();
    test_uart_write();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
